// File: rtl/audio_codec_i2c_config.sv
// Audio codec configuration master: walks a fixed 10-entry register table
// and writes each entry to the codec over I2C (open-drain, ~100 kHz SCL).
// Each NACKed transaction is retried up to 3 times before the sequence
// gives up and parks in ERROR with the bus released.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | after reset; launches the first sequence on the next edge
// S_START | start condition: SDA falls while SCL is high
// S_BIT   | one data bit, 4 quarters, SDA only moves while SCL is low
// S_ACK   | SDA released, slave response sampled at the end of q2
// S_STOP  | stop condition: SDA rises while SCL is high
// S_GAP   | bus idle between transactions, picks next entry or retry
// S_DONE  | every entry ACKed; waits for start
// S_ERROR | retries exhausted; bus released, waits for start

module audio_codec_i2c_config #(
   parameter int         sysclk_frequency = 1000,
   parameter logic [6:0] i2c_address      = 7'h1A
) (
   input  logic clk,
   input  logic reset_n,
   input  logic start,
   output logic busy,
   output logic done,
   output logic error,
   output logic i2c_scl_out,
   output logic i2c_sda_out,
   input  logic i2c_sda_in
);

   localparam int QTR_DIV_RAW = sysclk_frequency / 4;
   localparam int QTR_DIV     = (QTR_DIV_RAW < 1) ? 1 : QTR_DIV_RAW;
   localparam int DIV_W       = (QTR_DIV < 2) ? 1 : $clog2(QTR_DIV);
   localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(QTR_DIV - 1);
   localparam logic [7:0] ADDR_BYTE  = {i2c_address, 1'b0};
   localparam logic [3:0] LAST_ENTRY = 4'd9;

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_GAP, S_DONE, S_ERROR
   } state_t;

   // Codec register table, {reg[6:0], data[8:0]}, in the order it is written.
   function automatic logic [15:0] table_word(input logic [3:0] idx);
      logic [15:0] w;
      case (idx)
         4'd0:    w = {7'd15, 9'h000};
         4'd1:    w = {7'd0,  9'h017};
         4'd2:    w = {7'd1,  9'h017};
         4'd3:    w = {7'd2,  9'h079};
         4'd4:    w = {7'd3,  9'h079};
         4'd5:    w = {7'd4,  9'h012};
         4'd6:    w = {7'd5,  9'h000};
         4'd7:    w = {7'd6,  9'h000};
         4'd8:    w = {7'd7,  9'h042};
         4'd9:    w = {7'd9,  9'h001};
         default: w = 16'h0000;
      endcase
      return w;
   endfunction

   state_t           r_state;
   logic [1:0]       r_q;
   logic [3:0]       r_index;
   logic [2:0]       r_bit_cnt;
   logic [1:0]       r_retry;
   logic [1:0]       r_byte_sel;
   logic [7:0]       r_shift;
   logic             r_nack;
   logic             r_auto;
   logic             r_scl;
   logic             r_sda;
   logic             r_busy;
   logic             r_done;
   logic             r_error;
   logic [DIV_W-1:0] r_div_cnt;

   logic        w_tick;
   logic [15:0] w_word;
   logic [7:0]  w_next_byte;

   assign w_tick      = r_busy && (r_div_cnt == '0);
   assign w_word      = table_word(r_index);
   assign w_next_byte = (r_byte_sel == 2'd0) ? w_word[15:8] : w_word[7:0];

   assign busy        = r_busy;
   assign done        = r_done;
   assign error       = r_error;
   assign i2c_scl_out = r_scl;
   assign i2c_sda_out = r_sda;

   // Quarter-bit down-counter; parked at its reload value whenever idle so
   // the first quarter of a sequence is always full length.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_div_cnt <= '0;
      end else if (!r_busy || (r_div_cnt == '0)) begin
         r_div_cnt <= DIV_RELOAD;
      end else begin
         r_div_cnt <= r_div_cnt - DIV_W'(1);
      end
   end

   // Sequencer: every quarter tick advances the bus phase and registers the
   // SCL/SDA levels for the phase being entered.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_q        <= 2'd0;
         r_index    <= 4'd0;
         r_bit_cnt  <= 3'd0;
         r_retry    <= 2'd0;
         r_byte_sel <= 2'd0;
         r_shift    <= 8'h00;
         r_nack     <= 1'b0;
         r_auto     <= 1'b1;
         r_scl      <= 1'b1;
         r_sda      <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start || r_auto) begin
                  r_auto  <= 1'b0;
                  r_done  <= 1'b0;
                  r_error <= 1'b0;
                  r_busy  <= 1'b1;
                  r_index <= 4'd0;
                  r_retry <= 2'd0;
                  r_nack  <= 1'b0;
                  r_q     <= 2'd0;
                  r_scl   <= 1'b1;
                  r_sda   <= 1'b1;
                  r_state <= S_START;
               end
            end

            S_START: begin
               if (w_tick) begin
                  if (r_q == 2'd0) begin
                     r_q   <= 2'd1;
                     r_sda <= 1'b0;
                  end else begin
                     r_q        <= 2'd0;
                     r_scl      <= 1'b0;
                     r_shift    <= ADDR_BYTE;
                     r_sda      <= ADDR_BYTE[7];
                     r_bit_cnt  <= 3'd7;
                     r_byte_sel <= 2'd0;
                     r_state    <= S_BIT;
                  end
               end
            end

            S_BIT: begin
               if (w_tick) begin
                  r_q <= r_q + 2'd1;
                  if (r_q == 2'd1) begin
                     r_scl <= 1'b1;
                  end else if (r_q == 2'd3) begin
                     r_scl <= 1'b0;
                     if (r_bit_cnt == 3'd0) begin
                        r_sda   <= 1'b1;
                        r_state <= S_ACK;
                     end else begin
                        r_bit_cnt <= r_bit_cnt - 3'd1;
                        r_shift   <= {r_shift[6:0], 1'b0};
                        r_sda     <= r_shift[6];
                     end
                  end
               end
            end

            S_ACK: begin
               if (w_tick) begin
                  r_q <= r_q + 2'd1;
                  if (r_q == 2'd1) begin
                     r_scl <= 1'b1;
                  end else if (r_q == 2'd2) begin
                     r_nack <= i2c_sda_in;
                  end else if (r_q == 2'd3) begin
                     r_scl <= 1'b0;
                     if (r_nack || (r_byte_sel == 2'd2)) begin
                        r_sda   <= 1'b0;
                        r_state <= S_STOP;
                     end else begin
                        r_byte_sel <= r_byte_sel + 2'd1;
                        r_shift    <= w_next_byte;
                        r_sda      <= w_next_byte[7];
                        r_bit_cnt  <= 3'd7;
                        r_state    <= S_BIT;
                     end
                  end
               end
            end

            S_STOP: begin
               if (w_tick) begin
                  if (r_q == 2'd0) begin
                     r_q   <= 2'd1;
                     r_scl <= 1'b1;
                  end else if (r_q == 2'd1) begin
                     r_q   <= 2'd2;
                     r_sda <= 1'b1;
                  end else begin
                     r_q <= 2'd0;
                     if (r_nack && (r_retry == 2'd3)) begin
                        r_busy  <= 1'b0;
                        r_error <= 1'b1;
                        r_scl   <= 1'b1;
                        r_sda   <= 1'b1;
                        r_state <= S_ERROR;
                     end else begin
                        r_state <= S_GAP;
                     end
                  end
               end
            end

            S_GAP: begin
               if (w_tick) begin
                  r_q <= r_q + 2'd1;
                  if (r_q == 2'd3) begin
                     // Retry/advance is decided here so index==LAST_ENTRY
                     // unambiguously means the final entry just went out.
                     if (r_nack) begin
                        r_retry <= r_retry + 2'd1;
                        r_nack  <= 1'b0;
                        r_state <= S_START;
                     end else if (r_index == LAST_ENTRY) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                     end else begin
                        r_index <= r_index + 4'd1;
                        r_retry <= 2'd0;
                        r_state <= S_START;
                     end
                  end
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_audio_codec_i2c_config.sv
// Bench for audio_codec_i2c_config: decodes the I2C bus, plays an ACK/NACK
// slave following a per-entry plan, and compares the decoded transactions
// and final status against a table-level model of the configuration run.

module tb_audio_codec_i2c_config;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic start = 1'b0;
   logic busy, done, error, scl, sda_out, sda_in;
   logic slave_drive = 1'b0;

   assign sda_in = sda_out & ~slave_drive;

   always #5 clk = ~clk;

   audio_codec_i2c_config #(.sysclk_frequency(8), .i2c_address(7'h1A)) u_dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .busy(busy), .done(done), .error(error),
      .i2c_scl_out(scl), .i2c_sda_out(sda_out), .i2c_sda_in(sda_in));

   typedef struct packed {
      logic [1:0] n;
      logic [7:0] b0;
      logic [7:0] b1;
      logic [7:0] b2;
   } txn_t;

   typedef struct {
      int nack_entry;
      int nack_times;
      int nack_byte;
      int exp_done;
      int exp_error;
      int exp_starts;
   } vec_t;

   int checks = 0;
   int errors = 0;

   int plan_cnt[10];
   int plan_byte[10];
   txn_t obs_q[$];
   txn_t exp_q[$];

   // bus monitor / slave state (written only by the monitor process)
   logic prev_scl = 1'b1, prev_sda = 1'b1;
   logic [7:0] mon_sh = 8'h00;
   txn_t cur = '0;
   int in_txn = 0, bitpos = 0, nbytes = 0, txn_nacked = 0;
   int sl_entry = 0, sl_attempt = 0, starts = 0, stops = 0;
   int hi_len = 0, lo_len = 0, last_low = 0, sda_chg = 1;
   int tim_ok = 0, tim_bad = 0;

   task automatic chk(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // monitor + slave, evaluated on every falling clock edge
   initial begin
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            in_txn = 0; bitpos = 0; nbytes = 0; txn_nacked = 0;
            slave_drive = 1'b0; sl_entry = 0; sl_attempt = 0;
            starts = 0; stops = 0; obs_q.delete();
            prev_scl = 1'b1; prev_sda = 1'b1;
            hi_len = 0; lo_len = 0; last_low = 0; sda_chg = 1;
         end else begin
            if (prev_scl && scl && prev_sda && !sda_in) begin
               starts++; in_txn = 1; bitpos = 0; nbytes = 0; txn_nacked = 0; cur = '0;
            end else if (prev_scl && scl && !prev_sda && sda_in) begin
               stops++;
               if (in_txn != 0) begin
                  cur.n = 2'(nbytes);
                  obs_q.push_back(cur);
                  if (txn_nacked != 0) sl_attempt++;
                  else if (nbytes == 3) begin sl_entry++; sl_attempt = 0; end
               end
               in_txn = 0;
            end else if (!prev_scl && scl && in_txn != 0) begin
               if (bitpos < 8) begin
                  mon_sh = {mon_sh[6:0], sda_in};
                  bitpos++;
                  if (bitpos == 8) begin
                     case (nbytes)
                        0:       cur.b0 = mon_sh;
                        1:       cur.b1 = mon_sh;
                        default: cur.b2 = mon_sh;
                     endcase
                     nbytes++;
                  end
               end else begin
                  bitpos = 0;
               end
            end else if (prev_scl && !scl && in_txn != 0) begin
               if (bitpos == 8) begin
                  if (sl_entry < 10 && sl_attempt < plan_cnt[sl_entry] &&
                      (nbytes - 1) == plan_byte[sl_entry]) begin
                     txn_nacked = 1;
                     slave_drive = 1'b0;
                  end else begin
                     slave_drive = 1'b1;
                  end
               end else begin
                  slave_drive = 1'b0;
               end
            end
            // SCL period measurement; periods containing a START/STOP are skipped
            if (scl == prev_scl) begin
               if (scl) begin
                  hi_len++;
                  if (sda_in != prev_sda) sda_chg = 1;
               end else begin
                  lo_len++;
               end
            end else if (scl) begin
               last_low = lo_len; hi_len = 1; sda_chg = 0;
            end else begin
               if (sda_chg == 0) begin
                  if (hi_len == 4 && last_low == 4) tim_ok++;
                  else tim_bad++;
               end
               lo_len = 1;
            end
            prev_scl = scl;
            prev_sda = sda_in;
         end
      end
   end

   // table-level model: expected transaction list and final status
   task automatic build_model(output int m_done, output int m_error, output int m_starts);
      int regs[10] = '{15, 0, 1, 2, 3, 4, 5, 6, 7, 9};
      int dats[10] = '{0, 'h17, 'h17, 'h79, 'h79, 'h12, 0, 0, 'h42, 1};
      int word, hi, lo, attempts, n;
      txn_t t;
      exp_q.delete();
      m_starts = 0; m_error = 0;
      for (int e = 0; e < 10; e++) begin
         word = regs[e] * 512 + dats[e];
         hi = word / 256; lo = word % 256;
         attempts = (plan_cnt[e] >= 4) ? 4 : plan_cnt[e] + 1;
         for (int a = 0; a < attempts; a++) begin
            n = (a < plan_cnt[e]) ? plan_byte[e] + 1 : 3;
            t.n  = 2'(n);
            t.b0 = 8'('h1A * 2);
            t.b1 = (n > 1) ? 8'(hi) : 8'h00;
            t.b2 = (n > 2) ? 8'(lo) : 8'h00;
            exp_q.push_back(t);
            m_starts++;
         end
         if (plan_cnt[e] >= 4) begin
            m_error = 1;
            break;
         end
      end
      m_done = (m_error == 0) ? 1 : 0;
   endtask

   task automatic compare_txns(input int base);
      chk("txn_count", obs_q.size() - base, exp_q.size());
      for (int i = 0; i < exp_q.size() && (base + i) < obs_q.size(); i++) begin
         checks++;
         if (obs_q[base + i] != exp_q[i]) begin
            errors++;
            $display("FAIL txn[%0d]: got n=%0d %h %h %h expected n=%0d %h %h %h", i,
                     obs_q[base+i].n, obs_q[base+i].b0, obs_q[base+i].b1, obs_q[base+i].b2,
                     exp_q[i].n, exp_q[i].b0, exp_q[i].b1, exp_q[i].b2);
         end
      end
   endtask

   task automatic clear_plan();
      for (int e = 0; e < 10; e++) begin plan_cnt[e] = 0; plan_byte[e] = 0; end
   endtask

   task automatic do_reset();
      reset_n = 1'b0; start = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_scl", int'(scl), 1);
      chk("rst_sda", int'(sda_out), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_error", int'(error), 0);
      reset_n = 1'b1;
      @(posedge clk); #1;
      chk("auto_start_busy", int'(busy), 1);
   endtask

   task automatic run_to_end();
      int n = 0;
      while (!(done || error) && n < 20000) begin @(posedge clk); n++; end
      chk("run_timeout", (n < 20000) ? 1 : 0, 1);
      repeat (3) @(negedge clk);
      #1;
   endtask

   task automatic check_final(input int e_done, input int e_error, input int e_starts);
      chk("done", int'(done), e_done);
      chk("error", int'(error), e_error);
      chk("busy_end", int'(busy), 0);
      chk("scl_released", int'(scl), 1);
      chk("sda_released", int'(sda_out), 1);
      chk("starts", starts, e_starts);
      chk("stops", stops, starts);
   endtask

   vec_t vecs[5];
   int m_done, m_error, m_starts, base, s0, n;
   txn_t t;

   initial begin
      vecs[0] = '{-1, 0, 0, 1, 0, 10};
      vecs[1] = '{ 3, 1, 0, 1, 0, 11};
      vecs[2] = '{ 5, 4, 0, 0, 1,  9};
      vecs[3] = '{ 0, 3, 2, 1, 0, 13};
      vecs[4] = '{ 9, 4, 1, 0, 1, 13};

      for (int v = 0; v < 5; v++) begin
         clear_plan();
         if (vecs[v].nack_entry >= 0) begin
            plan_cnt[vecs[v].nack_entry]  = vecs[v].nack_times;
            plan_byte[vecs[v].nack_entry] = vecs[v].nack_byte;
         end
         do_reset();
         run_to_end();
         build_model(m_done, m_error, m_starts);
         check_final(vecs[v].exp_done, vecs[v].exp_error, vecs[v].exp_starts);
         chk("model_starts", starts, m_starts);
         chk("model_done", int'(done), m_done);
         compare_txns(0);
         if (v == 0 && obs_q.size() == 10) begin
            t = obs_q[0];
            chk("txn0_bytes", int'({t.n, t.b0, t.b1, t.b2}), int'({2'd3, 8'h34, 8'h1E, 8'h00}));
            t = obs_q[9];
            chk("txn9_bytes", int'({t.n, t.b0, t.b1, t.b2}), int'({2'd3, 8'h34, 8'h12, 8'h01}));
         end
      end

      // randomized NACK plans against the model
      for (int it = 0; it < 3; it++) begin
         for (int e = 0; e < 10; e++) begin
            plan_cnt[e]  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 4)) : 0;
            plan_byte[e] = int'($urandom_range(0, 2));
         end
         do_reset();
         run_to_end();
         build_model(m_done, m_error, m_starts);
         check_final(m_done, m_error, m_starts);
         compare_txns(0);
      end

      // start while busy is ignored; start after done restarts the table
      clear_plan();
      do_reset();
      n = 0;
      while (sl_entry != 4 && n < 5000) begin @(negedge clk); #1; n++; end
      chk("wait_entry4", (n < 5000) ? 1 : 0, 1);
      start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      chk("busy_after_mid_start", int'(busy), 1);
      run_to_end();
      build_model(m_done, m_error, m_starts);
      check_final(1, 0, 10);
      compare_txns(0);
      base = obs_q.size();
      s0 = starts;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("restart_done_clr", int'(done), 0);
      chk("restart_busy", int'(busy), 1);
      run_to_end();
      chk("restart_done", int'(done), 1);
      chk("restart_starts", starts - s0, 10);
      compare_txns(base);

      // reset in the middle of entry 2
      clear_plan();
      do_reset();
      n = 0;
      while (!(sl_entry == 2 && in_txn != 0 && nbytes == 1 && bitpos == 4) && n < 5000) begin
         @(negedge clk); #1; n++;
      end
      chk("wait_entry2_bit4", (n < 5000) ? 1 : 0, 1);
      reset_n = 1'b0;
      #1;
      chk("midrst_scl", int'(scl), 1);
      chk("midrst_sda", int'(sda_out), 1);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_error", int'(error), 0);
      repeat (4) @(negedge clk);
      #1;
      reset_n = 1'b1;
      run_to_end();
      build_model(m_done, m_error, m_starts);
      check_final(1, 0, 10);
      if (obs_q.size() > 0) begin
         t = obs_q[0];
         chk("post_rst_txn0", int'({t.n, t.b0, t.b1, t.b2}), int'({2'd3, 8'h34, 8'h1E, 8'h00}));
      end
      compare_txns(0);

      chk("scl_period_violations", tim_bad, 0);
      chk("scl_periods_measured", (tim_ok > 100) ? 1 : 0, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/audio_codec_i2c_config.md
AUDIO_CODEC_I2C_CONFIG -- requirements
Module: audio_codec_i2c_config

Interface
REQ-001 The block SHALL have the parameter sysclk_frequency, default 1000, meaning the clk frequency in units of 100 kHz.
REQ-002 The block SHALL have the parameter i2c_address, default 7'h1A, meaning the 7-bit codec device address; the write byte is {i2c_address,1'b0} = 8'h34.
REQ-003 The block SHALL have the port clk, input, 1 bit: system clock; all logic on its rising edge.
REQ-004 The block SHALL have the port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have the port start, input, 1 bit: restart request, sampled only while idle.
REQ-006 The block SHALL have the port busy, output, 1 bit: high while the sequence runs.
REQ-007 The block SHALL have the port done, output, 1 bit: high after all table entries are ACKed.
REQ-008 The block SHALL have the port error, output, 1 bit: high after retry exhaustion.
REQ-009 The block SHALL have the port i2c_scl_out, output, 1 bit: 0 drives SCL low, 1 releases it.
REQ-010 The block SHALL have the port i2c_sda_out, output, 1 bit: 0 drives SDA low, 1 releases it, using the open-drain convention the toplevels already use for PS/2.
REQ-011 The block SHALL have the port i2c_sda_in, input, 1 bit: sampled SDA line.

Function
REQ-012 A quarter-bit tick SHALL pulse once every sysclk_frequency/4 clk cycles (integer division, minimum 1), giving SCL at approximately 100 kHz; the divider SHALL run only while busy.
REQ-013 A fixed 10-entry table SHALL hold 16-bit words {reg[6:0],data[8:0]}, in this order: R15=0x000, R0=0x017, R1=0x017, R2=0x079, R3=0x079, R4=0x012, R5=0x000, R6=0x000, R7=0x042, R9=0x001.
REQ-014 Each transaction SHALL be: START, address byte 0x34, ACK, word[15:8], ACK, word[7:0], ACK, STOP; all bytes are sent MSB first.
REQ-015 The FSM states SHALL be IDLE, START, BIT, ACK, STOP, GAP, DONE, ERROR.
REQ-016 START SHALL hold SCL=1 and SDA=1 for one quarter, then SDA=0 with SCL=1 for one quarter, then SCL=0.
REQ-017 BIT (8 per byte, 4 quarters each) SHALL use: q0 SCL=0 with SDA updated; q1 SCL=0; q2 SCL=1; q3 SCL=1. SDA SHALL never change while SCL=1.
REQ-018 ACK SHALL release SDA for 4 quarters and sample i2c_sda_in at the end of q2. A sample of 0 is ACK; 1 is NACK.
REQ-019 On NACK, the block SHALL finish the current bit, issue STOP, then GAP, then retry the same entry from START; at most 3 retries per entry (4 attempts total).
REQ-020 If the 4th attempt is NACKed, the block SHALL issue STOP and enter ERROR: error=1, busy=0, done=0, bus released. Remaining entries SHALL NOT be sent.
REQ-021 STOP SHALL be: SDA=0 with SCL=0, SCL=1, then SDA=1, one quarter each.
REQ-022 GAP SHALL keep the bus released for 4 quarters between transactions.
REQ-023 After the STOP of entry 9 and its GAP, the FSM SHALL enter DONE: done=1, busy=0.
REQ-024 In IDLE, DONE or ERROR, a start=1 sample SHALL clear done and error, reset the entry index to 0, and set busy=1 on the next clk.
REQ-025 start SHALL be ignored while busy=1.
REQ-026 The first sequence SHALL begin automatically on the first clk edge after reset_n deasserts, without waiting for start.
REQ-027 The entry index SHALL be 4 bits, the bit counter 3 bits, and the retry counter 2 bits; the retry counter SHALL clear at each new entry.

Reset
REQ-028 While reset_n=0, the outputs SHALL be asynchronously forced to i2c_scl_out=1, i2c_sda_out=1, busy=0, done=0, error=0; the FSM to IDLE; and all counters to 0.
REQ-029 A reset during a transaction SHALL abandon it without issuing STOP; after reset release, the sequence SHALL restart from entry 0.

Verification
REQ-030 Bench: reset release with an always-ACK slave model -> 10 transactions decoded; transaction 0 bytes are 34,1E,00; transaction 9 bytes are 34,12,01; then done=1, error=0, busy=0.
REQ-031 Bench: single NACK on the address byte of entry 3 -> STOP, GAP, entry 3 resent; the sequence completes with done=1 and exactly 11 STARTs observed.
REQ-032 Bench: persistent NACK on entry 5 -> 4 attempts of entry 5, then error=1, done=0, busy=0, scl_out=sda_out=1; entries 6 to 9 are never sent.
REQ-033 Bench: start pulsed mid-sequence -> no effect. start pulsed after done -> done=0, busy=1 on the next clk, and the full 10-entry sequence repeats.
REQ-034 Bench: reset_n low during bit 4 of entry 2 -> outputs go to their released and zero values in the same cycle. After release, the first decoded transaction is entry 0.
REQ-035 Bench: sysclk_frequency=8 -> quarter tick every 2 clk cycles; SCL high and low periods each measure 4 clk cycles; SDA is stable whenever SCL=1, except at START and STOP edges.
